mmio_initiator: RTL and testbench

Synthesizable CCI-P MMIO initiator: it accepts single register-access commands from a local controller or test sequencer and drives them into an AFU as MMIO write and read requests. For reads it waits for the AFU's read response with the matching transaction ID and returns the data. It sits on the host side of the AFU MMIO interface, in the position the FIU occupies. It drives the AFU's RX channel-0 MMIO signals and consumes the AFU's TX channel-2 read responses.

---
 rtl/mmio_initiator.sv | 167 ++++++++++++++++
 tb/tb_mmio_initiator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_initiator.sv
// Host-side CCI-P MMIO initiator: turns single register-access commands into AFU
// MMIO write/read requests and returns completions, matching read responses by tid.
module mmio_initiator #(
    parameter int TIMEOUT = 512,
    parameter int TID_W   = 9
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [15:0]      cmd_addr,
    input  logic [63:0]      cmd_data,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic             rsp_error,
    output logic             rsp_timeout,

    output logic             mmio_wr_valid,
    output logic             mmio_rd_valid,
    output logic [15:0]      mmio_addr,
    output logic [TID_W-1:0] mmio_tid,
    output logic [63:0]      mmio_data,

    input  logic             rd_rsp_valid,
    input  logic [TID_W-1:0] rd_rsp_tid,
    input  logic [63:0]      rd_rsp_data,

    output logic [15:0]      stale_count
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    logic               cmd_write_q;
    logic [TID_W-1:0]   tid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        stale_q;
    logic [15:0]        stale_d;
    logic               rsp_valid_q;
    logic [63:0]        rsp_data_q;
    logic               rsp_error_q;
    logic               rsp_timeout_q;
    logic               mmio_wr_valid_q;
    logic               mmio_rd_valid_q;
    logic [15:0]        mmio_addr_q;
    logic [TID_W-1:0]   mmio_tid_q;
    logic [63:0]        mmio_data_q;
    logic               rsp_match;

    // Any response that does not complete the outstanding read is stale.
    always_comb begin
        rsp_match = (state_q == WAIT) && rd_rsp_valid && (rd_rsp_tid == tid_q);
        stale_d   = stale_q;
        if (rd_rsp_valid && !rsp_match && (stale_q != 16'hFFFF)) begin
            stale_d = stale_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cmd_write_q     <= 1'b0;
            tid_q           <= '0;
            cnt_q           <= '0;
            stale_q         <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_error_q     <= 1'b0;
            rsp_timeout_q   <= 1'b0;
            mmio_wr_valid_q <= 1'b0;
            mmio_rd_valid_q <= 1'b0;
            mmio_addr_q     <= '0;
            mmio_tid_q      <= '0;
            mmio_data_q     <= '0;
        end else begin
            stale_q <= stale_d;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_write_q <= cmd_write;
                        if (cmd_addr[0]) begin
                            // Odd dword address: reject without touching the AFU or the tid.
                            rsp_error_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            mmio_addr_q     <= cmd_addr;
                            mmio_data_q     <= cmd_data;
                            mmio_tid_q      <= tid_q;
                            mmio_wr_valid_q <= cmd_write;
                            mmio_rd_valid_q <= !cmd_write;
                            state_q         <= REQ;
                        end
                    end
                end

                REQ: begin
                    mmio_wr_valid_q <= 1'b0;
                    mmio_rd_valid_q <= 1'b0;
                    cnt_q           <= '0;
                    if (cmd_write_q) begin
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        state_q     <= WAIT;
                    end
                end

                WAIT: begin
                    if (rsp_match) begin
                        rsp_data_q  <= rd_rsp_data;
                        rsp_valid_q <= 1'b1;
                        tid_q       <= tid_q + TID_W'(1);
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_timeout_q <= 1'b1;
                        rsp_data_q    <= '0;
                        rsp_valid_q   <= 1'b1;
                        tid_q         <= tid_q + TID_W'(1);
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_error_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        rsp_data_q    <= '0;
                        state_q       <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_error     = rsp_error_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign mmio_wr_valid = mmio_wr_valid_q;
    assign mmio_rd_valid = mmio_rd_valid_q;
    assign mmio_addr     = mmio_addr_q;
    assign mmio_tid      = mmio_tid_q;
    assign mmio_data     = mmio_data_q;
    assign stale_count   = stale_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed self-checking bench for mmio_initiator, with an inline AFU model that
// answers reads one cycle after the request (echo, silent, or wrong-tid-first).
module tb_mmio_initiator;

    localparam int TIMEOUT = 16;
    localparam int TID_W   = 9;
    localparam logic [63:0] DFH = 64'h1000010000000000;

    logic             clock;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [15:0]      cmd_addr;
    logic [63:0]      cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_data;
    logic             rsp_error;
    logic             rsp_timeout;
    logic             mmio_wr_valid;
    logic             mmio_rd_valid;
    logic [15:0]      mmio_addr;
    logic [TID_W-1:0] mmio_tid;
    logic [63:0]      mmio_data;
    logic             rd_rsp_valid;
    logic [TID_W-1:0] rd_rsp_tid;
    logic [63:0]      rd_rsp_data;
    logic [15:0]      stale_count;

    int testCount;
    int failCount;

    // AFU model controls: 0 = silent, 1 = echo, 2 = wrong tid first then correct 3 cycles later
    int               afuMode;
    int               delayedLeft;
    logic [TID_W-1:0] delayedTid;
    logic [63:0]      delayedData;
    logic             injectNow;
    logic [TID_W-1:0] injectTid;

    mmio_initiator #(
        .TIMEOUT(TIMEOUT),
        .TID_W  (TID_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .rsp_timeout  (rsp_timeout),
        .mmio_wr_valid(mmio_wr_valid),
        .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr    (mmio_addr),
        .mmio_tid     (mmio_tid),
        .mmio_data    (mmio_data),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_tid   (rd_rsp_tid),
        .rd_rsp_data  (rd_rsp_data),
        .stale_count  (stale_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] afuData(input logic [15:0] addr);
        if (addr == 16'h0000) return DFH;
        return 64'hCAFE000000000000 | {48'h0, addr};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock: the AFU reacts to the strobe seen in the cycle that is ending.
    task automatic tick();
        logic             sawRd;
        logic [TID_W-1:0] sawTid;
        logic [15:0]      sawAddr;
        sawRd   = mmio_rd_valid;
        sawTid  = mmio_tid;
        sawAddr = mmio_addr;
        @(posedge clock);
        #1;
        rd_rsp_valid = 1'b0;
        if (injectNow) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_tid   = injectTid;
            rd_rsp_data  = 64'hDEAD;
            injectNow    = 1'b0;
        end else if (sawRd && afuMode == 1) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_tid   = sawTid;
            rd_rsp_data  = afuData(sawAddr);
        end else if (sawRd && afuMode == 2) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_tid   = sawTid + 9'd1;
            rd_rsp_data  = 64'hBAD0BAD0BAD0BAD0;
            delayedLeft  = 3;
            delayedTid   = sawTid;
            delayedData  = afuData(sawAddr);
        end else if (delayedLeft > 0) begin
            delayedLeft--;
            if (delayedLeft == 0) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_tid   = delayedTid;
                rd_rsp_data  = delayedData;
            end
        end
    endtask

    // Present one command for the accepting edge; returns in cycle T1.
    task automatic applyStimulus(input logic write, input logic [15:0] addr, input logic [63:0] data);
        cmd_valid = 1'b1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input string tag, input int expCycles);
        int cyc;
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput({tag, " latency"}, 64'(cyc), 64'(expCycles));
    endtask

    task automatic ackRsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int badCount;
        int cyc;
        testCount    = 0;
        failCount    = 0;
        afuMode      = 0;
        delayedLeft  = 0;
        delayedTid   = '0;
        delayedData  = '0;
        injectNow    = 1'b0;
        injectTid    = '0;
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_addr     = '0;
        cmd_data     = '0;
        rsp_ready    = 1'b0;
        rd_rsp_valid = 1'b0;
        rd_rsp_tid   = '0;
        rd_rsp_data  = '0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset cmd_ready", cmd_ready, 1);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_data", rsp_data, 0);
        checkOutput("reset mmio_tid", mmio_tid, 0);
        checkOutput("reset stale_count", stale_count, 0);
        reset = 1'b0;
        tick();

        // Write: strobe in T1 only, completion in T2
        applyStimulus(1'b1, 16'h0010, 64'h04C11DB7);
        checkOutput("wr strobe", mmio_wr_valid, 1);
        checkOutput("wr no rd strobe", mmio_rd_valid, 0);
        checkOutput("wr addr", mmio_addr, 16'h0010);
        checkOutput("wr data", mmio_data, 64'h04C11DB7);
        checkOutput("wr cmd_ready busy", cmd_ready, 0);
        waitRsp("wr", 2);
        checkOutput("wr strobe dropped", mmio_wr_valid, 0);
        checkOutput("wr rsp_data", rsp_data, 0);
        checkOutput("wr rsp_error", rsp_error, 0);
        checkOutput("wr rsp_timeout", rsp_timeout, 0);
        ackRsp();
        checkOutput("wr back to idle", cmd_ready, 1);
        checkOutput("wr rsp_valid cleared", rsp_valid, 0);

        // Read of the DFH with an echoing AFU
        afuMode = 1;
        applyStimulus(1'b0, 16'h0000, 64'h0);
        checkOutput("rd0 strobe", mmio_rd_valid, 1);
        checkOutput("rd0 tid", mmio_tid, 0);
        waitRsp("rd0", 3);
        checkOutput("rd0 data", rsp_data, DFH);
        checkOutput("rd0 rsp_timeout", rsp_timeout, 0);
        ackRsp();

        // Silent AFU: timeout, then a late response counts as stale
        afuMode = 0;
        applyStimulus(1'b0, 16'h0020, 64'h0);
        checkOutput("to tid advanced", mmio_tid, 1);
        waitRsp("to", TIMEOUT + 2);
        checkOutput("to flag", rsp_timeout, 1);
        checkOutput("to data", rsp_data, 0);
        checkOutput("to stale before", stale_count, 0);
        injectNow = 1'b1;
        injectTid = 9'd1;
        tick();
        tick();
        checkOutput("to late stale", stale_count, 1);
        checkOutput("to rsp held", rsp_valid, 1);
        ackRsp();

        // Wrong tid first, right tid 3 cycles later
        afuMode = 2;
        applyStimulus(1'b0, 16'h0008, 64'h0);
        checkOutput("wt tid", mmio_tid, 2);
        waitRsp("wt", 6);
        checkOutput("wt data", rsp_data, 64'hCAFE000000000008);
        checkOutput("wt stale", stale_count, 2);
        ackRsp();

        // Odd address: error, no strobe, tid and mmio_addr untouched
        afuMode = 1;
        applyStimulus(1'b0, 16'h0011, 64'h0);
        checkOutput("odd no rd strobe", mmio_rd_valid, 0);
        checkOutput("odd no wr strobe", mmio_wr_valid, 0);
        checkOutput("odd addr held", mmio_addr, 16'h0008);
        waitRsp("odd", 1);
        checkOutput("odd error", rsp_error, 1);
        checkOutput("odd data", rsp_data, 0);
        ackRsp();
        applyStimulus(1'b0, 16'h0004, 64'h0);
        checkOutput("post-odd tid", mmio_tid, 3);
        waitRsp("post-odd", 3);
        ackRsp();

        // Walk the tid up to 511 with quick reads
        badCount = 0;
        for (int i = 4; i < 511; i++) begin
            applyStimulus(1'b0, 16'h0002, 64'h0);
            cyc = 1;
            while (!rsp_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            if (cyc != 3 || rsp_data !== 64'hCAFE000000000002) badCount++;
            ackRsp();
        end
        checkOutput("walk bad reads", 64'(badCount), 0);
        applyStimulus(1'b0, 16'h0006, 64'h0);
        checkOutput("tid 511", mmio_tid, 9'd511);
        waitRsp("tid 511", 3);
        checkOutput("tid 511 data", rsp_data, 64'hCAFE000000000006);
        ackRsp();
        applyStimulus(1'b0, 16'h000A, 64'h0);
        checkOutput("tid wrap", mmio_tid, 0);
        waitRsp("tid wrap", 3);
        ackRsp();
        checkOutput("walk stale", stale_count, 2);

        // Asynchronous reset in the middle of WAIT
        afuMode = 0;
        applyStimulus(1'b0, 16'h0030, 64'h55);
        tick();
        tick();
        reset = 1'b1;
        #2;
        checkOutput("arst cmd_ready", cmd_ready, 1);
        checkOutput("arst rsp_valid", rsp_valid, 0);
        checkOutput("arst rd strobe", mmio_rd_valid, 0);
        checkOutput("arst mmio_addr", mmio_addr, 0);
        checkOutput("arst mmio_data", mmio_data, 0);
        checkOutput("arst mmio_tid", mmio_tid, 0);
        checkOutput("arst stale", stale_count, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 16'h0040, 64'h1234);
        checkOutput("arst wr strobe", mmio_wr_valid, 1);
        checkOutput("arst wr data", mmio_data, 64'h1234);
        waitRsp("arst wr", 2);
        ackRsp();
        injectNow = 1'b1;
        injectTid = 9'd5;
        tick();
        tick();
        checkOutput("arst late stale", stale_count, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
